unet_pvm_mac_requant: RTL and testbench

Accumulate-and-requantize stage directly downstream of the `unet_pvm_top` signed 18×12 multiplier. It consumes a stream of 30-bit signed products, one per kernel tap, and sums each group into a wide accumulator with a per-group bias. At the group's last beat it rounds, shifts and saturates the sum to an 18-bit signed activation. That activation width matches the multiplier's `din0` width, so the next layer can take the output directly.

---
 rtl/unet_pvm_pkg.sv | 38 +++
 rtl/unet_pvm_requant.sv | 70 +++++++
 rtl/unet_pvm_mac_requant.sv | 154 +++++++++++++++
 tb/tb_unet_pvm_mac_requant.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unet_pvm_pkg.sv
// -----------------------------------------------------------------------------
// unet_pvm_pkg
//
// Shared definitions for the unet_pvm accumulate/requantize slice.
//   - Default widths for the product, accumulator, activation and shift amount.
//   - State encoding for the accumulate/requantize controller.
//   - Helpers that give the signed saturation bounds of an activation width,
//     plus those bounds for the default activation width.
// No ports: this file only holds types, constants and constant functions.
// -----------------------------------------------------------------------------
package unet_pvm_pkg;

    localparam int DEF_PROD_WIDTH  = 30;
    localparam int DEF_ACC_WIDTH   = 40;
    localparam int DEF_OUT_WIDTH   = 18;
    localparam int DEF_SHIFT_WIDTH = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RQ   = 2'd2,
        OUT  = 2'd3
    } pvmState_t;

    // Largest value a signed activation of the given width can hold.
    function automatic longint satHigh(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    // Smallest value a signed activation of the given width can hold.
    function automatic longint satLow(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

    localparam longint SAT_MAX = satHigh(DEF_OUT_WIDTH);
    localparam longint SAT_MIN = satLow(DEF_OUT_WIDTH);

endpackage

// File: rtl/unet_pvm_requant.sv
// -----------------------------------------------------------------------------
// unet_pvm_requant
//
// Purely combinational requantizer: round-half-up, arithmetic right shift,
// saturate to a signed OUT_WIDTH activation and, when UNET_PVM_RELU_EN is
// defined, clamp negative results to zero after saturation.
//
// Ports
//   sum     in  ACC_WIDTH    signed accumulated group sum
//   amount  in  SHIFT_WIDTH  right-shift amount
//   result  out OUT_WIDTH    signed requantized activation
//   clipped out 1            high when saturation changed the value
//
// Build option: UNET_PVM_RELU_EN (ReLU clamp after saturation; `clipped`
// reflects saturation only).
// -----------------------------------------------------------------------------
module unet_pvm_requant
    import unet_pvm_pkg::*;
#(
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0]   sum,
    input  logic [SHIFT_WIDTH-1:0] amount,
    output logic [OUT_WIDTH-1:0]   result,
    output logic                   clipped
);

    localparam logic [OUT_WIDTH-1:0] OUT_HI = OUT_WIDTH'(satHigh(OUT_WIDTH));
    localparam logic [OUT_WIDTH-1:0] OUT_LO = OUT_WIDTH'(satLow(OUT_WIDTH));

    // One guard bit above the accumulator keeps the rounding increment from
    // wrapping a sum that sits near the top of the accumulator range.
    logic signed [ACC_WIDTH:0]         sumExt;
    logic signed [ACC_WIDTH:0]         roundInc;
    logic signed [ACC_WIDTH:0]         rounded;
    logic signed [ACC_WIDTH:0]         shifted;
    logic [ACC_WIDTH-OUT_WIDTH+1:0]    headBits;
    logic                              fits;
    logic [OUT_WIDTH-1:0]              clamped;

    // Round by adding half an output LSB, shift arithmetically, then clip.
    // The shifted value fits the activation exactly when every bit from the
    // activation sign bit upward agrees; otherwise it clips toward its sign.
    always_comb begin
        sumExt   = {sum[ACC_WIDTH-1], sum};
        roundInc = '0;
        if (amount != '0) begin
            roundInc = (ACC_WIDTH+1)'(1) << (amount - SHIFT_WIDTH'(1));
        end
        rounded  = sumExt + roundInc;
        shifted  = rounded >>> amount;
        headBits = shifted[ACC_WIDTH:OUT_WIDTH-1];
        fits     = (&headBits) || !(|headBits);
        clipped  = 1'b0;
        clamped  = shifted[OUT_WIDTH-1:0];
        if (!fits) begin
            clipped = 1'b1;
            clamped = shifted[ACC_WIDTH] ? OUT_LO : OUT_HI;
        end
`ifdef UNET_PVM_RELU_EN
        if (clamped[OUT_WIDTH-1]) begin
            clamped = '0;
        end
`endif
        result = clamped;
    end

endmodule

// File: rtl/unet_pvm_mac_requant.sv
// -----------------------------------------------------------------------------
// unet_pvm_mac_requant
//
// Accumulate-and-requantize stage behind the unet_pvm multiplier. Products of
// one kernel group are summed with a per-group bias into a wide accumulator;
// after the group's last beat the sum is rounded, shifted and saturated to a
// signed activation, which is held until the consumer takes it.
//
// Ports
//   ap_clk     in  1            clock, rising edge
//   ap_rst_n   in  1            asynchronous active-low reset
//   in_prod    in  PROD_WIDTH   signed product
//   in_valid   in  1            in_prod valid
//   in_last    in  1            final beat of a group
//   in_ready   out 1            stage accepts a beat (IDLE/ACC only)
//   bias       in  PROD_WIDTH   signed group bias, taken on the first beat
//   shift      in  SHIFT_WIDTH  requant shift, taken on the first beat
//   out_data   out OUT_WIDTH    signed activation
//   out_valid  out 1            out_data valid
//   out_ready  in  1            consumer accepts out_data
//   out_sat    out 1            out_data was clipped by saturation
//   busy       out 1            controller is not idle
//
// Build option: UNET_PVM_RELU_EN (negative activations forced to zero).
// -----------------------------------------------------------------------------
module unet_pvm_mac_requant
    import unet_pvm_pkg::*;
#(
    parameter int PROD_WIDTH  = DEF_PROD_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [PROD_WIDTH-1:0]  in_prod,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    input  logic [PROD_WIDTH-1:0]  bias,
    input  logic [SHIFT_WIDTH-1:0] shift,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_sat,
    output logic                   busy
);

    pvmState_t              state;
    pvmState_t              nextState;
    logic [ACC_WIDTH-1:0]   acc;
    logic [SHIFT_WIDTH-1:0] shiftLatch;
    logic                   readyEn;
    logic                   accept;
    logic [ACC_WIDTH-1:0]   prodExt;
    logic [ACC_WIDTH-1:0]   biasExt;
    logic [OUT_WIDTH-1:0]   rqData;
    logic                   rqSat;

    assign prodExt = {{(ACC_WIDTH-PROD_WIDTH){in_prod[PROD_WIDTH-1]}}, in_prod};
    assign biasExt = {{(ACC_WIDTH-PROD_WIDTH){bias[PROD_WIDTH-1]}}, bias};

    // in_ready must stay low while reset is held even though the state sits
    // in IDLE, so readiness is qualified by a flop that only sets on the
    // first clock edge after reset is released.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            readyEn <= 1'b0;
        end else begin
            readyEn <= 1'b1;
        end
    end

    assign in_ready  = readyEn && ((state == IDLE) || (state == ACC));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    // Controller state register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: a group ends on its accepted last beat, spends one
    // cycle in RQ while the requantized result is registered, then waits in
    // OUT for the consumer handshake.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = in_last ? RQ : ACC;
                end
            end
            ACC: begin
                if (accept && in_last) begin
                    nextState = RQ;
                end
            end
            RQ: begin
                nextState = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Datapath: the first beat of a group seeds the accumulator with the bias
    // and captures the shift; later beats add on. The requantized result is
    // captured in RQ and then held untouched through OUT.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc        <= '0;
            shiftLatch <= '0;
            out_data   <= '0;
            out_sat    <= 1'b0;
        end else begin
            if (accept) begin
                if (state == IDLE) begin
                    acc        <= biasExt + prodExt;
                    shiftLatch <= shift;
                end else begin
                    acc <= acc + prodExt;
                end
            end
            if (state == RQ) begin
                out_data <= rqData;
                out_sat  <= rqSat;
            end
        end
    end

    unet_pvm_requant #(
        .ACC_WIDTH   (ACC_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) requantUnit (
        .sum     (acc),
        .amount  (shiftLatch),
        .result  (rqData),
        .clipped (rqSat)
    );

endmodule

// File: tb/tb_unet_pvm_mac_requant.sv
// -----------------------------------------------------------------------------
// tb_unet_pvm_mac_requant
//
// Self-checking bench for unet_pvm_mac_requant. A group-level model (sum of
// accepted products plus bias, then integer round/shift/clip) predicts every
// result; a compare process checks handshake outputs and held data on every
// negative clock edge. Directed groups also pin literal expected values.
// Honours UNET_PVM_RELU_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_unet_pvm_mac_requant;

    localparam int PW = 30;
    localparam int AW = 40;
    localparam int OW = 18;
    localparam int SW = 5;
`ifdef UNET_PVM_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic [PW-1:0] in_prod;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [PW-1:0] bias;
    logic [SW-1:0] shift;
    logic [OW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sat;
    logic          busy;

    always #5 ap_clk = ~ap_clk;

    unet_pvm_mac_requant dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .bias      (bias),
        .shift     (shift),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    typedef struct {
        longint data;
        bit     sat;
    } result_t;

    int      total = 0;
    int      bad = 0;
    result_t expQ[$];
    longint  beatQ[$];
    longint  modelSum = 0;
    int      modelShift = 0;
    bit      modelActive = 1'b0;
    bit      seenEdge = 1'b0;
    int      edgesSinceLast = -1;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string name, input longint actual, input longint expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference requant of a whole group sum: round half up, floor shift, clip.
    function automatic result_t requantRef(input longint s, input int sh);
        result_t res;
        longint  w;
        longint  r;
        longint  q;
        w = (s <<< 24) >>> 24;
        r = w + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
        q = r >>> sh;
        res.data = q;
        res.sat  = 1'b0;
        if (q > 131071) begin
            res.data = 131071;
            res.sat  = 1'b1;
        end else if (q < -131072) begin
            res.data = -131072;
            res.sat  = 1'b1;
        end
        if (RELU && res.data < 0) begin
            res.data = 0;
        end
        return res;
    endfunction

    // Model update on each rising edge from the accepted handshakes; reset
    // throws away any partial group and pending result.
    always @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            expQ.delete();
            modelActive    = 1'b0;
            modelSum       = 0;
            edgesSinceLast = -1;
            seenEdge       = 1'b0;
        end else begin
            seenEdge = 1'b1;
            if (edgesSinceLast >= 0 && edgesSinceLast < 1000) begin
                edgesSinceLast++;
            end
            if (out_valid && out_ready && expQ.size() != 0) begin
                void'(expQ.pop_front());
            end
            if (in_valid && in_ready) begin
                if (!modelActive) begin
                    modelSum   = longint'($signed(bias)) + longint'($signed(in_prod));
                    modelShift = int'(shift);
                end else begin
                    modelSum = modelSum + longint'($signed(in_prod));
                end
                modelActive = 1'b1;
                if (in_last) begin
                    expQ.push_back(requantRef(modelSum, modelShift));
                    modelActive    = 1'b0;
                    edgesSinceLast = 0;
                end
            end
        end
    end

    // Compare outputs against the model on every falling edge out of reset.
    always @(negedge ap_clk) begin
        bit expValid;
        if (ap_rst_n) begin
            expValid = (expQ.size() != 0) && (edgesSinceLast != 0);
            checkOutput("out_valid", longint'(out_valid), longint'(expValid));
            checkOutput("busy", longint'(busy), longint'(modelActive || expQ.size() != 0));
            if (seenEdge) begin
                checkOutput("in_ready", longint'(in_ready), longint'(expQ.size() == 0));
            end
            if (expValid && out_valid) begin
                checkOutput("out_data model", longint'($signed(out_data)), expQ[0].data);
                checkOutput("out_sat model", longint'(out_sat), longint'(expQ[0].sat));
            end
        end
    end

    // Drive the group held in beatQ; bias/shift are only meaningful on the
    // first beat, so later beats carry junk there.
    task automatic applyStimulus(input longint b, input int s);
        int w;
        for (int i = 0; i < beatQ.size(); i++) begin
            in_valid = 1'b1;
            in_prod  = PW'(beatQ[i]);
            in_last  = (i == beatQ.size() - 1);
            if (i == 0) begin
                bias  = PW'(b);
                shift = SW'(s);
            end else begin
                bias  = PW'($urandom);
                shift = SW'($urandom);
            end
            w = 0;
            while (!in_ready && w < 100) begin
                @(negedge ap_clk);
                w++;
            end
            if (w >= 100) begin
                checkOutput("in_ready wait", longint'(in_ready), 1);
            end
            @(negedge ap_clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for a result and compare it with literal values.
    task automatic expectResult(input string name, input longint data, input bit sat);
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
            @(negedge ap_clk);
            w++;
        end
        checkOutput({name, " valid"}, longint'(out_valid), 1);
        checkOutput({name, " data"}, longint'($signed(out_data)), data);
        checkOutput({name, " sat"}, longint'(out_sat), longint'(sat));
        if (out_ready) begin
            @(negedge ap_clk);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        bias      = '0;
        shift     = '0;
        out_ready = 1'b1;
        ap_rst_n  = 1'b0;

        repeat (2) @(negedge ap_clk);
        checkOutput("reset in_ready", longint'(in_ready), 0);
        checkOutput("reset out_valid", longint'(out_valid), 0);
        checkOutput("reset out_data", longint'($signed(out_data)), 0);
        checkOutput("reset out_sat", longint'(out_sat), 0);
        checkOutput("reset busy", longint'(busy), 0);
        #2 ap_rst_n = 1'b1;
        @(negedge ap_clk);
        checkOutput("in_ready after reset", longint'(in_ready), 1);

        beatQ = '{100};
        applyStimulus(0, 0);
        expectResult("single beat", 100, 1'b0);

        beatQ = '{1000, -200, 50};
        applyStimulus(10, 2);
        expectResult("three beat", 215, 1'b0);

        beatQ = '{-6};
        applyStimulus(0, 2);
        expectResult("round -6", RELU ? 0 : -1, 1'b0);

        beatQ = '{-7};
        applyStimulus(0, 2);
        expectResult("round -7", RELU ? 0 : -2, 1'b0);

        beatQ = '{536870911, 536870911};
        applyStimulus(0, 0);
        expectResult("sat high", 131071, 1'b1);

        beatQ = '{-536870912, -536870912};
        applyStimulus(0, 0);
        expectResult("sat low", RELU ? 0 : -131072, 1'b1);

        beatQ = '{131071};
        applyStimulus(0, 0);
        expectResult("edge max", 131071, 1'b0);

        beatQ = '{131072};
        applyStimulus(0, 0);
        expectResult("edge over", 131071, 1'b1);

        beatQ = '{-131072};
        applyStimulus(0, 0);
        expectResult("edge min", RELU ? 0 : -131072, 1'b0);

        // Backpressure: result held, no beat taken while stalled.
        out_ready = 1'b0;
        beatQ = '{3000};
        applyStimulus(0, 3);
        expectResult("stall result", 375, 1'b0);
        in_valid = 1'b1;
        in_prod  = PW'(999);
        in_last  = 1'b1;
        bias     = '0;
        shift    = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            checkOutput("stall data", longint'($signed(out_data)), 375);
            checkOutput("stall in_ready", longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge ap_clk);
        checkOutput("after handshake valid", longint'(out_valid), 0);
        beatQ = '{-40, 8};
        applyStimulus(4, 1);
        expectResult("after stall", RELU ? 0 : -14, 1'b0);

        // Reset in the middle of a four-beat group.
        while (!in_ready) @(negedge ap_clk);
        in_valid = 1'b1;
        in_prod  = PW'(500);
        in_last  = 1'b0;
        bias     = PW'(3);
        shift    = '0;
        @(negedge ap_clk);
        in_prod  = PW'(600);
        @(negedge ap_clk);
        in_valid = 1'b0;
        checkOutput("mid group busy", longint'(busy), 1);
        #2 ap_rst_n = 1'b0;
        #1;
        checkOutput("mid reset busy", longint'(busy), 0);
        checkOutput("mid reset in_ready", longint'(in_ready), 0);
        checkOutput("mid reset out_valid", longint'(out_valid), 0);
        @(negedge ap_clk);
        #2 ap_rst_n = 1'b1;
        repeat (6) @(negedge ap_clk);
        beatQ = '{7};
        applyStimulus(0, 0);
        expectResult("after reset", 7, 1'b0);

        repeat (3) @(negedge ap_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
